regfile_dump_reader: RTL

Sequential reader for the 32×64 register file's two registered read ports. On a `start` pulse it walks an inclusive register range `first_id..last_id`, two registers per read transaction. It then streams each `{id, data}` pair out one beat at a time over a valid/ready interface. It sits beside the register file and serves the debug/trace path, replacing time-driven dumps with an on-demand, back-pressurable stream.

---
 rtl/regfile_pkg.sv | 38 +++
 rtl/regfile_dump_reader_rf_pair_buffer.sv | 46 ++++
 rtl/regfile_dump_reader.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared constants, dump FSM states and beat type for the
//               32x64 register file and its trace consumers.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int N     = 64;
    localparam int R     = 32;
    localparam int ASIZE = $clog2(R);

    typedef logic [ASIZE-1:0] reg_id_t;
    typedef logic [N-1:0]     reg_data_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        CAPTURE = 3'd2,
        SEND0   = 3'd3,
        SEND1   = 3'd4,
        FIN     = 3'd5
    } dump_state_t;

    typedef struct packed {
        reg_id_t   id;
        reg_data_t data;
        logic      last;
    } beat_t;

    // Register ids wrap modulo R, so R-1 + 1 lands on 0.
    function automatic reg_id_t next_id(input reg_id_t id);
        return id + 1'b1;
    endfunction

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_dump_reader_rf_pair_buffer.sv
`default_nettype none
// ============================================================================
// Module      : rf_pair_buffer
// Description : Two-entry capture buffer holding one register pair and ids.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_pair_buffer
    import regfile_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 sel,
    input  logic [ASIZE-1:0]     id0,
    input  logic [N-1:0]         data0,
    input  logic [ASIZE-1:0]     id1,
    input  logic [N-1:0]         data1,
    output logic [ASIZE-1:0]     out_id,
    output logic [N-1:0]         out_data
);

    reg_id_t   r_id0;
    reg_id_t   r_id1;
    reg_data_t r_data0;
    reg_data_t r_data1;

    // Contents change only on load, so a stalled beat stays frozen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_id0   <= '0;
            r_id1   <= '0;
            r_data0 <= '0;
            r_data1 <= '0;
        end else if (load) begin
            r_id0   <= id0;
            r_id1   <= id1;
            r_data0 <= data0;
            r_data1 <= data1;
        end
    end

    assign out_id   = sel ? r_id1   : r_id0;
    assign out_data = sel ? r_data1 : r_data0;

endmodule : rf_pair_buffer
`default_nettype wire

// File: rtl/regfile_dump_reader.sv
`default_nettype none
// ============================================================================
// Module      : regfile_dump_reader
// Description : Walks a register range two ids at a time through the register
//               file read ports and streams {id, data} beats over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_dump_reader
    import regfile_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [ASIZE-1:0]     first_id,
    input  logic [ASIZE-1:0]     last_id,
    output logic [ASIZE-1:0]     rd_id1,
    output logic [ASIZE-1:0]     rd_id2,
    input  logic [N-1:0]         rd_data1,
    input  logic [N-1:0]         rd_data2,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ASIZE-1:0]     out_id,
    output logic [N-1:0]         out_data,
    output logic                 out_last,
    output logic                 busy,
    output logic                 done
);

    dump_state_t r_state;
    dump_state_t w_next_state;

    reg_id_t   r_ptr;
    reg_id_t   r_last_id;
    reg_id_t   r_hold_id1;
    reg_id_t   r_hold_id2;

    reg_id_t   w_ptr_p1;
    reg_id_t   w_buf_id;
    reg_data_t w_buf_data;
    logic      w_valid;
    logic      w_handshake;
    logic      w_buf_load;
    logic      w_buf_sel;
    beat_t     w_beat;

    assign w_ptr_p1    = next_id(r_ptr);
    assign w_valid     = (r_state == SEND0) || (r_state == SEND1);
    assign w_handshake = w_valid && out_ready;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_state = (first_id > last_id) ? FIN : ISSUE;
                end
            end
            ISSUE:   w_next_state = CAPTURE;
            CAPTURE: w_next_state = SEND0;
            SEND0: begin
                if (w_handshake) begin
                    w_next_state = (r_ptr == r_last_id) ? FIN : SEND1;
                end
            end
            SEND1: begin
                if (w_handshake) begin
                    w_next_state = (w_ptr_p1 == r_last_id) ? FIN : ISSUE;
                end
            end
            FIN:     w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Range pointer and read-port id hold registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr      <= '0;
            r_last_id  <= '0;
            r_hold_id1 <= '0;
            r_hold_id2 <= '0;
        end else begin
            if ((r_state == IDLE) && start) begin
                r_ptr     <= first_id;
                r_last_id <= last_id;
            end
            if (r_state == ISSUE) begin
                r_hold_id1 <= r_ptr;
                r_hold_id2 <= w_ptr_p1;
            end
            if ((r_state == SEND1) && (w_next_state == ISSUE)) begin
                r_ptr <= next_id(w_ptr_p1);
            end
        end
    end

    rf_pair_buffer u_pair_buffer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_buf_load),
        .sel      (w_buf_sel),
        .id0      (r_ptr),
        .data0    (rd_data1),
        .id1      (w_ptr_p1),
        .data1    (rd_data2),
        .out_id   (w_buf_id),
        .out_data (w_buf_data)
    );

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_buf_load  = (r_state == CAPTURE);
        w_buf_sel   = (r_state == SEND1);
        busy        = (r_state != IDLE);
        done        = (r_state == FIN);

        // Ids are combinational in ISSUE so the one-cycle read lands in CAPTURE.
        rd_id1      = (r_state == ISSUE) ? r_ptr    : r_hold_id1;
        rd_id2      = (r_state == ISSUE) ? w_ptr_p1 : r_hold_id2;

        w_beat.id   = w_buf_id;
        w_beat.data = w_buf_data;
        w_beat.last = (w_buf_id == r_last_id);

        out_valid   = w_valid;
        out_id      = w_valid ? w_beat.id   : '0;
        out_data    = w_valid ? w_beat.data : '0;
        out_last    = w_valid ? w_beat.last : 1'b0;
    end

endmodule : regfile_dump_reader
`default_nettype wire
